data_mem_lsu: RTL
=================

# data_mem_lsu

Byte-addressable RV32 data memory with a valid/ready request port and a one-cycle response pulse. It supports every RV32I load/store width (byte, half, word; signed and unsigned loads), little-endian byte ordering, configurable depth and wait-state latency, and optional misalignment/illegal-size detection. It sits between the execute stage's load/store path and the data array, and replaces the older fixed-size word/byte data memory.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, request address width
- MEM_DEPTH_LOG2, 16, log2 of array size in bytes (2..24)
- WAIT_CYCLES, 0, extra wait states before array access (0..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  block can accept a request
- WE  in  1  1 = store, 0 = load
- Funct3  in  3  RV32 access size/sign (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101)
- Address  in  ADDRESS_WIDTH  byte address
- WriteData  in  32  store data; low byte/half used for SB/SH
- RespValid  out  1  one-cycle response pulse
- ReadData  out  32  load result, extended to 32 bits; 0 for stores
- RespErr  out  1  access rejected; valid with RespValid

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: ReqReady=1. A request is accepted on the edge where ReqValid && ReqReady. Address, WE, Funct3 and WriteData are captured. Next state is WAIT if WAIT_CYCLES>0, otherwise ACCESS.
- WAIT: the counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle. At 0 the FSM goes to ACCESS.
- ACCESS: on the exiting edge, the store writes the enabled byte lanes, or the load data is registered. The FSM goes to RESP.
- RESP: RespValid=1 for exactly one cycle, then IDLE. Requests are never accepted outside IDLE.
- Byte order is little-endian: byte lane k = Address[1:0]+k, and the LSB of the data sits at the lowest address.
- Byte (SB) writes byte Address.
- Half (SH) writes bytes {Address[..:1],0} and +1.
- Word (SW) writes the 4 bytes at {Address[..:2],00}.
- Load extension:
  - LB and LH sign-extend from bit 7 and bit 15.
  - LBU and LHU zero-extend.
  - LW returns the word unchanged.
- Address bits at and above MEM_DEPTH_LOG2 are ignored, so accesses wrap modulo the array size.
- Array contents are not reset and are X until written.

## Timing
- Request accepted in cycle c, which is also the capture edge. RespValid is high in cycle c+WAIT_CYCLES+2.
- Throughput: one request per WAIT_CYCLES+3 cycles.
- ReqReady is a combinational function of state==IDLE && rst_n. It is 0 while rst_n is low.
- ReadData and RespErr are registered. Both are held at their last value after RESP, and both are meaningful only when RespValid is high.
- Reset values: state IDLE, RespValid 0, ReadData 0, RespErr 0, wait counter 0.
- Reset mid-operation:
  - The pending request is discarded and no response is issued.
  - A store whose ACCESS edge coincides with rst_n low is not written; the array write is gated by rst_n.
- ReqValid may drop at any time before acceptance; the block has no obligation until acceptance.

## Configuration
- DATA_MEM_ALIGN_CHECK_EN defined:
  - Rejected accesses: a half at an odd address, a word with Address[1:0]≠0, or Funct3 011/110/111.
  - A rejected access still runs the full FSM timing.
  - In RESP it gives RespErr=1 and ReadData=0, and the array is unmodified.
- Undefined:
  - Low address bits are forced: half uses Address[1], word ignores Address[1:0].
  - Illegal Funct3 is treated as LW/SW.
  - RespErr is tied to 0.

## Structure
- Package data_mem_pkg holds:
  - the Funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum
  - the lane-mask and extend helper functions
  - the WAIT_CYCLES upper bound
- Sub-module data_mem_byte_ram:
  - 4-lane byte array of 2**(MEM_DEPTH_LOG2-2) words
  - 4-bit byte-enable write
  - registered word read
- The FSM, lane alignment and sign extension stay in data_mem_lsu.

## Test plan
- SW 0x11223344 @0x100, then LW @0x100 -> ReadData 0x11223344, RespErr 0.
- LBU @0x103 -> 0x00000011; LH @0x102 -> 0x00001122; LB @0x100 -> 0x00000044.
- SB 0x80 @0x101, then LB @0x101 -> 0xFFFFFF80 and LBU @0x101 -> 0x00000080; LW @0x100 -> 0x11228044.
- WAIT_CYCLES=3: ReqValid accepted in cycle 0 -> RespValid only in cycle 5; ReqReady 0 in cycles 1–5, 1 in cycle 6.
- With DATA_MEM_ALIGN_CHECK_EN: SW 0xDEADBEEF @0x102 -> RespErr 1; a following LW @0x100 still gives 0x11228044.
  - Without the macro, the same SW writes 0x100 and LW @0x100 gives 0xDEADBEEF.
- rst_n pulsed low during WAIT of an SW 0xAAAAAAAA @0x200 -> no RespValid, outputs 0, ReqReady 1 after release. LW @0x200 does not return 0xAAAAAAAA; it returns the pre-write contents.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the RV32 data memory load/store unit.
// Lane-mask, store-replication and load-extension logic live here so the top stays FSM-only.
package data_mem_pkg;

    localparam int WAIT_MAX = 15;
    localparam int WAIT_W   = 4;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: lane_mask = 4'b0001 << a;
            F3_H, F3_HU: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:     lane_mask = 4'b1111;
        endcase
    endfunction

    // Replicate the low byte/half across lanes; the lane mask picks the one that lands.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B, F3_BU: store_data = {4{wd[7:0]}};
            F3_H, F3_HU: store_data = {2{wd[15:0]}};
            default:     store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {a, 3'b000});
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_BU:   load_extend = {24'h0, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_HU:   load_extend = {16'h0, h};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = a[0];
            F3_W:        misaligned = (a != 2'b00);
            default:     misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_byte_ram.sv
// Four-lane byte array with per-lane write enables and a registered word read.
// Contents are intentionally not reset.
module data_mem_byte_ram #(
    parameter int WORDS_LOG2 = 14
) (
    input  logic                  clk,
    input  logic [WORDS_LOG2-1:0] rd_addr_i,
    input  logic [WORDS_LOG2-1:0] wr_addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] lane_q [2**WORDS_LOG2];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i && be_i[k]) begin
                lane_q[wr_addr_i] <= wdata_i[8*k +: 8];
            end
            rd_q <= lane_q[rd_addr_i];
        end

        assign rdata_o[8*k +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 load/store data memory: valid/ready request, optional wait states, one-cycle response.
// Define DATA_MEM_ALIGN_CHECK_EN to reject misaligned accesses and illegal Funct3 with RespErr.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MEM_DEPTH_LOG2 = 16,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic                     WE,
    input  logic [2:0]               Funct3,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [31:0]              WriteData,
    output logic                     RespValid,
    output logic [31:0]              ReadData,
    output logic                     RespErr
);

    localparam int               WL2       = MEM_DEPTH_LOG2 - 2;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e                    state_q, state_d;
    logic [WAIT_W-1:0]         cnt_q, cnt_d;
    logic [MEM_DEPTH_LOG2-1:0] addr_q;
    logic                      we_q;
    logic [2:0]                f3_q;
    logic [31:0]               wdata_q;
    logic [31:0]               rdata_q;
    logic                      err_q;
    logic                      accept;
    logic                      bad;
    logic                      ram_we;
    logic [WL2-1:0]            ram_rd_addr;
    logic [31:0]               ram_rdata;
    logic                      unused_addr_hi;

    assign unused_addr_hi = ^Address[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2];

    assign ReqReady  = (state_q == S_IDLE) && rst_n;
    assign accept    = ReqValid && ReqReady;
    assign RespValid = (state_q == S_RESP);
    assign ReadData  = rdata_q;
    assign RespErr   = err_q;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign bad = misaligned(f3_q, addr_q[1:0]);
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= Address[MEM_DEPTH_LOG2-1:0];
                we_q    <= WE;
                f3_q    <= Funct3;
                wdata_q <= WriteData;
            end
            if (state_q == S_ACCESS) begin
                rdata_q <= (we_q || bad) ? 32'h0 : load_extend(f3_q, addr_q[1:0], ram_rdata);
                err_q   <= bad;
            end
        end
    end

    // The read port tracks the incoming address on acceptance so the word is ready
    // in ACCESS even with zero wait states.
    assign ram_rd_addr = accept ? Address[MEM_DEPTH_LOG2-1:2] : addr_q[MEM_DEPTH_LOG2-1:2];
    assign ram_we      = (state_q == S_ACCESS) && we_q && !bad && rst_n;

    data_mem_byte_ram #(
        .WORDS_LOG2(WL2)
    ) u_ram (
        .clk       (clk),
        .rd_addr_i (ram_rd_addr),
        .wr_addr_i (addr_q[MEM_DEPTH_LOG2-1:2]),
        .we_i      (ram_we),
        .be_i      (lane_mask(f3_q, addr_q[1:0])),
        .wdata_i   (store_data(f3_q, wdata_q)),
        .rdata_o   (ram_rdata)
    );

endmodule
